spike_injector: RTL and testbench
=================================

Name: spike_injector

Overview:
- Edge-of-mesh packet source that feeds a core's west input port; it is the transmitter side of the router read-enable/empty handshake.
- The host loads one frame of 30-bit spike packets. The block drains them into the core, waits for the core's tick_ready, then issues a one-cycle tick.
- Sits between the host/SoC bus bridge and the west_in / empty_in_west / ren_out_west pins of the core.

Parameters:
- FIFO_DEPTH, 16, packet buffer entries; must be a power of 2, at least 2.
- PACKET_WIDTH, 30, packet width: dx[29:21], dy[20:12], delivery tick[11:8], axon[7:0].
- CNT_WIDTH, 8, width of the per-frame sent-packet counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- host_wen  in  1  host write strobe.
- host_data  in  PACKET_WIDTH  packet to enqueue.
- host_full  out  1  host must not write; high when FIFO full or state != IDLE.
- frame_go  in  1  one-cycle pulse: start sending the loaded frame.
- dout  out  PACKET_WIDTH  head of FIFO; drives core west_in.
- empty_out  out  1  drives core empty_in_west; equals fifo_empty OR state != SEND.
- ren_in  in  1  from core ren_out_west; pops the head entry.
- tick_ready  in  1  from core; frame fully consumed.
- tick  out  1  to core; one-cycle pulse.
- frame_done  out  1  one-cycle pulse, coincident with tick.
- sent_count  out  CNT_WIDTH  packets popped in the current or last frame.
- err_flags  out  3  sticky: [0] write rejected, [1] read underflow, [2] timeout.

Behaviour:
- Reset (synchronous, active-low):
  - FIFO pointers and the occupancy count clear.
  - State goes to IDLE.
  - tick=0, frame_done=0, sent_count=0, err_flags=0, empty_out=1, dout=0.
  - A reset asserted mid-frame discards all queued packets; no tick is issued.
- FIFO behaviour:
  - First-word fall-through: dout is the head entry combinationally.
  - A pop on ren_in takes effect at the clock edge; the next entry appears the following cycle.
  - The count is log2(FIFO_DEPTH)+1 bits wide; pointers wrap modulo FIFO_DEPTH.
- Write acceptance:
  - A write is accepted only when host_wen=1, state==IDLE and the FIFO is not full.
  - Any other host_wen is dropped and sets err_flags[0].
- Pop acceptance:
  - A pop is accepted only when ren_in=1 and empty_out=0. Each accepted pop increments sent_count; sent_count saturates at all-ones.
  - ren_in while empty_out=1 moves no pointer and sets err_flags[1].
- State machine:
  - IDLE:
    - frame_go with FIFO non-empty goes to SEND; sent_count clears.
    - frame_go with FIFO empty goes to TICK (zero-packet frame; no wait).
  - SEND: when the FIFO becomes empty after a pop, go to WAIT_READY on the next edge.
  - WAIT_READY: go to TICK on tick_ready=1.
  - TICK:
    - tick=1 and frame_done=1 for exactly one cycle, then IDLE.
    - err_flags are not cleared; they clear only on reset.
- Latencies:
  - frame_go to empty_out low: 1 cycle.
  - tick_ready to tick high: 1 cycle.
  - Zero-packet frame: frame_go to tick: 1 cycle.
- Early tick_ready: a tick_ready pulse arriving during SEND is latched in ready_seen. Entering WAIT_READY with ready_seen=1 goes straight to TICK. ready_seen clears in TICK.
- Ignored inputs:
  - frame_go outside IDLE is ignored.
  - tick_ready in IDLE or TICK is ignored.
- Simultaneous pop and last-entry write cannot occur, because writes are only accepted in IDLE.

Optional Feature:
- Macro: SPIKE_INJECTOR_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 1024) and a counter that runs in WAIT_READY and clears on entry.
  - On reaching TIMEOUT_CYCLES-1 without tick_ready, go to TICK anyway and set err_flags[2]. This recovers from a core that never asserts tick_ready (e.g. a single-packet frame).
- Not defined:
  - WAIT_READY waits indefinitely.
  - err_flags[2] is tied to 0.

Decomposition:
- Package snn_pkt_pkg:
  - PACKET_WIDTH.
  - Field offsets and widths: DX 9, DY 9, TICK 4, AXON 8.
  - State encoding (IDLE=0, SEND=1, WAIT_READY=2, TICK=3).
  - Error-bit index constants.
- Sub-module spike_inj_fifo:
  - Parameterised by depth and width.
  - Ports: wen, ren, din, dout, full, empty, count.
  - Holds the storage, pointers and occupancy count.
- The top-level block holds the FSM, counters, error flags and optional watchdog.

Test Plan:
- Reset → empty_out=1, tick=0, host_full=0, err_flags=3'b000; hold reset_n low mid-SEND with 5 queued → FIFO empty and state IDLE after release.
- Normal frame → packets written in order, 1 cycle apart; core readback matches FIFO order with no loss.
  - Write 0x0000001, 0x0000002, 0x0000003; frame_go; ren_in held high.
  - dout shows them in order, one per cycle; empty_out=1 after the third pop; sent_count=3.
  - tick_ready pulse → tick=1 and frame_done=1 exactly one cycle later.
- Full FIFO → 16 writes make host_full=1; a 17th write is dropped and err_flags[0]=1; sending then delivers exactly 16 packets.
- Zero-packet frame → frame_go with an empty FIFO gives tick one cycle later; empty_out never deasserts.
- Misuse inputs:
  - ren_in pulsed in IDLE → err_flags[1]=1, no pointer movement.
  - tick_ready pulsed during SEND → latched; tick arrives one cycle after WAIT_READY entry.
- Timeout (SPIKE_INJECTOR_TIMEOUT_EN, TIMEOUT_CYCLES=8) → with no tick_ready, tick arrives 8 cycles after WAIT_READY entry and err_flags[2]=1.

Source files
------------

// File: rtl/snn_pkt_pkg.sv
// Shared definitions for the spike packet path: packet layout, injector
// state encoding and error-flag bit positions.
package snn_pkt_pkg;

  localparam int PACKET_WIDTH = 30;

  // Packet fields, MSB to LSB: dx | dy | delivery tick | axon
  localparam int DX_W     = 9;
  localparam int DY_W     = 9;
  localparam int TICK_W   = 4;
  localparam int AXON_W   = 8;
  localparam int AXON_LSB = 0;
  localparam int TICK_LSB = AXON_LSB + AXON_W;
  localparam int DY_LSB   = TICK_LSB + TICK_W;
  localparam int DX_LSB   = DY_LSB + DY_W;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEND       = 2'd1,
    ST_WAIT_READY = 2'd2,
    ST_TICK       = 2'd3
  } inj_state_e;

  localparam int ERR_W         = 3;
  localparam int ERR_WR_REJECT = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_TIMEOUT   = 2;

endpackage

// File: rtl/spike_inj_fifo.sv
// First-word fall-through packet buffer for the spike injector. The caller
// only presents qualified write/pop strobes; dout reads 0 while empty.
module spike_inj_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 30
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wen,
  input  logic                       ren,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of 2)
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wen) wptr_d = wptr_q + AW'(1);
    if (ren) rptr_d = rptr_q + AW'(1);
    case ({wen, ren})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers take reset; storage does not need it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (wen) mem_q[wptr_q] <= din;
  end

  // Head of queue presented combinationally, zero when nothing is queued
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == (AW+1)'(DEPTH));
    count = count_q;
    dout  = empty ? '0 : mem_q[rptr_q];
  end

endmodule

// File: rtl/spike_injector.sv
// Edge-of-mesh spike source: host loads a frame, the block drains it into a
// core's west port over the ren/empty handshake, then issues one tick.
// Optional WAIT_READY watchdog: define SPIKE_INJECTOR_TIMEOUT_EN.
module spike_injector
  import snn_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int PACKET_WIDTH = snn_pkt_pkg::PACKET_WIDTH,
  parameter int CNT_WIDTH    = 8
`ifdef SPIKE_INJECTOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    host_wen,
  input  logic [PACKET_WIDTH-1:0] host_data,
  output logic                    host_full,
  input  logic                    frame_go,
  output logic [PACKET_WIDTH-1:0] dout,
  output logic                    empty_out,
  input  logic                    ren_in,
  input  logic                    tick_ready,
  output logic                    tick,
  output logic                    frame_done,
  output logic [CNT_WIDTH-1:0]    sent_count,
  output logic [2:0]              err_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);

  inj_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 ready_seen_q, ready_seen_d;
  logic                 fifo_full, fifo_empty;
  logic [AW:0]          fifo_count;
  logic                 wr_accept, pop_accept, timeout_hit;

  spike_inj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wen     (wr_accept),
    .ren     (pop_accept),
    .din     (host_data),
    .dout    (dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef SPIKE_INJECTOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

  // Watchdog counts cycles spent in WAIT_READY; zero on entry
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ST_WAIT_READY) wait_cnt_d = wait_cnt_q + TO_W'(1);
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (!reset_n) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end

  assign timeout_hit = (state_q == ST_WAIT_READY) &&
                       (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Handshake qualification: host side only in IDLE, core side only in SEND
  always_comb begin
    empty_out  = fifo_empty || (state_q != ST_SEND);
    host_full  = fifo_full || (state_q != ST_IDLE);
    wr_accept  = host_wen && (state_q == ST_IDLE) && !fifo_full;
    pop_accept = ren_in && !empty_out;
  end

  // Frame sequencing, sent counter, sticky errors and early-ready latch
  always_comb begin
    state_d      = state_q;
    sent_d       = sent_q;
    err_d        = err_q;
    ready_seen_d = ready_seen_q;
    if (host_wen && !wr_accept) err_d[ERR_WR_REJECT] = 1'b1;
    if (ren_in && empty_out)    err_d[ERR_UNDERFLOW] = 1'b1;
    if (pop_accept && (sent_q != '1)) sent_d = sent_q + CNT_WIDTH'(1);
    case (state_q)
      ST_IDLE: begin
        if (frame_go) begin
          sent_d  = '0;
          state_d = (fifo_count != '0) ? ST_SEND : ST_TICK;
        end
      end
      ST_SEND: begin
        if (tick_ready) ready_seen_d = 1'b1;
        if (fifo_empty) state_d = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (tick_ready || ready_seen_q) begin
          state_d = ST_TICK;
        end else if (timeout_hit) begin
          state_d              = ST_TICK;
          err_d[ERR_TIMEOUT]   = 1'b1;
        end
      end
      ST_TICK: begin
        ready_seen_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sent_q       <= '0;
      err_q        <= '0;
      ready_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sent_q       <= sent_d;
      err_q        <= err_d;
      ready_seen_q <= ready_seen_d;
    end
  end

  // Registered-state outputs
  always_comb begin
    tick       = (state_q == ST_TICK);
    frame_done = (state_q == ST_TICK);
    sent_count = sent_q;
    err_flags  = err_q;
  end

endmodule

// File: tb/tb_spike_injector.sv
// Self-checking bench for spike_injector: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_spike_injector;

  localparam int DEPTH = 16;
  localparam int PW    = 30;
  localparam int CW    = 8;
`ifdef SPIKE_INJECTOR_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          host_wen;
  logic [PW-1:0] host_data;
  logic          host_full;
  logic          frame_go;
  logic [PW-1:0] dout;
  logic          empty_out;
  logic          ren_in;
  logic          tick_ready;
  logic          tick;
  logic          frame_done;
  logic [CW-1:0] sent_count;
  logic [2:0]    err_flags;

  always #5 clk = ~clk;

  spike_injector #(
    .FIFO_DEPTH   (DEPTH),
    .PACKET_WIDTH (PW),
    .CNT_WIDTH    (CW)
`ifdef SPIKE_INJECTOR_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host_wen   (host_wen),
    .host_data  (host_data),
    .host_full  (host_full),
    .frame_go   (frame_go),
    .dout       (dout),
    .empty_out  (empty_out),
    .ren_in     (ren_in),
    .tick_ready (tick_ready),
    .tick       (tick),
    .frame_done (frame_done),
    .sent_count (sent_count),
    .err_flags  (err_flags)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    host_wen   = 1'b0;
    host_data  = '0;
    frame_go   = 1'b0;
    ren_in     = 1'b0;
    tick_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [PW-1:0] d);
    host_wen  = 1'b1;
    host_data = d;
    cyc();
    host_wen  = 1'b0;
  endtask

  task automatic go();
    frame_go = 1'b1;
    cyc();
    frame_go = 1'b0;
  endtask

  typedef struct {
    logic          wen;
    logic [PW-1:0] data;
    logic          go;
    logic          ren;
    logic          trdy;
    logic          e_empty;
    logic [PW-1:0] e_dout;
    logic          e_full;
    logic          e_tick;
    logic [CW-1:0] e_sent;
    logic [2:0]    e_err;
  } vec_t;

  function automatic vec_t mk(input logic wen, input logic [PW-1:0] data, input logic g,
                              input logic ren, input logic trdy, input logic e_empty,
                              input logic [PW-1:0] e_dout, input logic e_full,
                              input logic e_tick, input logic [CW-1:0] e_sent);
    vec_t v;
    v.wen = wen; v.data = data; v.go = g; v.ren = ren; v.trdy = trdy;
    v.e_empty = e_empty; v.e_dout = e_dout; v.e_full = e_full;
    v.e_tick = e_tick; v.e_sent = e_sent; v.e_err = 3'b000;
    return v;
  endfunction

  vec_t vecs[11];

  typedef enum int {M_IDLE, M_SENDING, M_AWAIT, M_TICKING} mph_e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    idle_in();

    // ---- reset values, sampled while reset is held
    reset_n = 1'b0;
    cyc();
    cyc();
    chk("rst empty_out", empty_out, 1);
    chk("rst tick", tick, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst host_full", host_full, 0);
    chk("rst err_flags", err_flags, 0);
    chk("rst sent_count", sent_count, 0);
    chk("rst dout", dout, 0);
    reset_n = 1'b1;

    // ---- normal three-packet frame, one row per clock
    //              wen data   go ren rdy | empty dout full tick sent
    vecs[0]  = mk(1, 30'h1, 0, 0, 0,   1, 30'h1, 0, 0, 0);
    vecs[1]  = mk(1, 30'h2, 0, 0, 0,   1, 30'h1, 0, 0, 0);
    vecs[2]  = mk(1, 30'h3, 0, 0, 0,   1, 30'h1, 0, 0, 0);
    vecs[3]  = mk(0, 30'h0, 1, 0, 0,   0, 30'h1, 1, 0, 0);
    vecs[4]  = mk(0, 30'h0, 0, 1, 0,   0, 30'h2, 1, 0, 1);
    vecs[5]  = mk(0, 30'h0, 0, 1, 0,   0, 30'h3, 1, 0, 2);
    vecs[6]  = mk(0, 30'h0, 0, 1, 0,   1, 30'h0, 1, 0, 3);
    vecs[7]  = mk(0, 30'h0, 0, 0, 0,   1, 30'h0, 1, 0, 3);
    vecs[8]  = mk(0, 30'h0, 0, 0, 0,   1, 30'h0, 1, 0, 3);
    vecs[9]  = mk(0, 30'h0, 0, 0, 1,   1, 30'h0, 1, 1, 3);
    vecs[10] = mk(0, 30'h0, 0, 0, 0,   1, 30'h0, 0, 0, 3);
    for (int i = 0; i < 11; i++) begin
      host_wen = vecs[i].wen; host_data = vecs[i].data; frame_go = vecs[i].go;
      ren_in = vecs[i].ren; tick_ready = vecs[i].trdy;
      cyc();
      chk($sformatf("vec%0d empty_out", i), empty_out, vecs[i].e_empty);
      chk($sformatf("vec%0d dout", i), dout, vecs[i].e_dout);
      chk($sformatf("vec%0d host_full", i), host_full, vecs[i].e_full);
      chk($sformatf("vec%0d tick", i), tick, vecs[i].e_tick);
      chk($sformatf("vec%0d frame_done", i), frame_done, vecs[i].e_tick);
      chk($sformatf("vec%0d sent_count", i), sent_count, vecs[i].e_sent);
      chk($sformatf("vec%0d err_flags", i), err_flags, vecs[i].e_err);
    end
    idle_in();

    // ---- full FIFO: 16 accepted, 17th rejected, exactly 16 delivered
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr(PW'(32'h100 + i));
    chk("full host_full", host_full, 1);
    chk("full no err yet", err_flags, 0);
    wr(30'h3ff_ffff);
    chk("full reject err", err_flags, 3'b001);
    go();
    ren_in = 1'b1;
    n = 0;
    while (!empty_out && n < 40) begin
      chk($sformatf("full pop%0d dout", n), dout, 32'h100 + n);
      cyc();
      n++;
    end
    ren_in = 1'b0;
    chk("full pop count", n, DEPTH);
    chk("full sent_count", sent_count, DEPTH);
    chk("full err after drain", err_flags, 3'b001);
    tick_ready = 1'b1;
    cyc();
    tick_ready = 1'b0;
    n = 0;
    while (!tick && n < 10) begin cyc(); n++; end
    chk("full frame tick", tick, 1);
    cyc();

    // ---- zero-packet frame
    do_reset();
    go();
    chk("zero tick", tick, 1);
    chk("zero frame_done", frame_done, 1);
    chk("zero empty_out", empty_out, 1);
    chk("zero sent_count", sent_count, 0);
    cyc();
    chk("zero tick drop", tick, 0);
    chk("zero empty_out after", empty_out, 1);
    chk("zero idle host_full", host_full, 0);

    // ---- ren_in in IDLE: underflow flag, no pointer movement
    do_reset();
    wr(30'h0aa);
    wr(30'h0bb);
    ren_in = 1'b1;
    cyc();
    ren_in = 1'b0;
    chk("uf err_flags", err_flags, 3'b010);
    chk("uf dout held", dout, 30'h0aa);
    go();
    chk("uf first", dout, 30'h0aa);
    ren_in = 1'b1;
    cyc();
    chk("uf second", dout, 30'h0bb);
    cyc();
    ren_in = 1'b0;
    chk("uf drained", empty_out, 1);
    chk("uf sent_count", sent_count, 2);

    // ---- tick_ready ignored in IDLE, latched during SEND
    do_reset();
    tick_ready = 1'b1;
    cyc();
    tick_ready = 1'b0;
    chk("idle rdy no tick", tick, 0);
    wr(30'h5);
    wr(30'h6);
    go();
    tick_ready = 1'b1;
    cyc();
    tick_ready = 1'b0;
    chk("early rdy no tick", tick, 0);
    ren_in = 1'b1;
    cyc();
    cyc();
    ren_in = 1'b0;
    chk("early drained", empty_out, 1);
    cyc();
    chk("early wait entry", tick, 0);
    cyc();
    chk("early tick", tick, 1);
    chk("early err_flags", err_flags, 0);

    // ---- reset mid-SEND with queued packets
    do_reset();
    for (int i = 0; i < 5; i++) wr(PW'(32'h20 + i));
    go();
    ren_in = 1'b1;
    cyc();
    ren_in = 1'b0;
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    chk("midrst empty_out", empty_out, 1);
    chk("midrst host_full", host_full, 0);
    chk("midrst dout", dout, 0);
    chk("midrst tick", tick, 0);
    chk("midrst sent", sent_count, 0);
    go();
    chk("midrst fifo empty", tick, 1);

    // ---- WAIT_READY with no tick_ready
    do_reset();
    wr(30'h7);
    go();
    ren_in = 1'b1;
    cyc();
    ren_in = 1'b0;
    cyc();
    n = 0;
    while (!tick && n < 60) begin cyc(); n++; end
`ifdef SPIKE_INJECTOR_TIMEOUT_EN
    chk("timeout cycles", n, TO);
    chk("timeout err_flags", err_flags, 3'b100);
`else
    chk("no timeout tick", tick, 0);
    chk("no timeout err_flags", err_flags, 0);
    tick_ready = 1'b1;
    cyc();
    tick_ready = 1'b0;
    chk("late rdy tick", tick, 1);
`endif

    // ---- randomized run against reference model
    do_reset();
    begin
      logic [PW-1:0] q[$];
      mph_e ph = M_IDLE;
      bit seen = 0;
      int wait_n = 0;
      int sent = 0;
      logic [2:0] err = 3'b000;
      for (int c = 0; c < 3000; c++) begin
        int sz;
        bit eo;
        mph_e nph;
        reset_n    = ($urandom_range(0, 199) != 0);
        host_wen   = ($urandom_range(0, 99) < ((ph == M_IDLE) ? 50 : 5));
        host_data  = PW'($urandom);
        frame_go   = ($urandom_range(0, 99) < 8);
        ren_in     = ($urandom_range(0, 99) < ((ph == M_SENDING) ? 60 : 3));
        tick_ready = ($urandom_range(0, 99) < 10);
        if (!reset_n) begin
          q.delete(); ph = M_IDLE; seen = 0; wait_n = 0; sent = 0; err = 3'b000;
        end else begin
          sz = q.size();
          eo = (sz == 0) || (ph != M_SENDING);
          nph = ph;
          if (host_wen) begin
            if (ph == M_IDLE && sz < DEPTH) q.push_back(host_data);
            else err[0] = 1'b1;
          end
          if (ren_in) begin
            if (!eo) begin
              void'(q.pop_front());
              if (sent < 255) sent++;
            end else err[1] = 1'b1;
          end
          case (ph)
            M_IDLE: if (frame_go) begin
              sent = 0;
              nph = (sz > 0) ? M_SENDING : M_TICKING;
            end
            M_SENDING: begin
              if (tick_ready) seen = 1;
              if (sz == 0) begin nph = M_AWAIT; wait_n = 0; end
            end
            M_AWAIT: begin
              if (tick_ready || seen) nph = M_TICKING;
`ifdef SPIKE_INJECTOR_TIMEOUT_EN
              else if (wait_n == TO - 1) begin nph = M_TICKING; err[2] = 1'b1; end
`endif
              wait_n++;
            end
            default: begin seen = 0; nph = M_IDLE; end
          endcase
          ph = nph;
        end
        cyc();
        chk($sformatf("rnd%0d tick", c), tick, ph == M_TICKING);
        chk($sformatf("rnd%0d frame_done", c), frame_done, ph == M_TICKING);
        chk($sformatf("rnd%0d empty_out", c), empty_out, (q.size() == 0) || (ph != M_SENDING));
        chk($sformatf("rnd%0d dout", c), dout, (q.size() > 0) ? q[0] : '0);
        chk($sformatf("rnd%0d host_full", c), host_full, (q.size() == DEPTH) || (ph != M_IDLE));
        chk($sformatf("rnd%0d sent_count", c), sent_count, sent);
        chk($sformatf("rnd%0d err_flags", c), err_flags, err);
      end
    end
    idle_in();
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
